// File: rtl/param_bus_datapath.sv
// param_bus_datapath
//   Parametrised single-bus processor datapath. A general register file, HI/LO,
//   Y, a double-width Z, MDR, MAR and the I/O port registers all share one bus.
//   Bus sources are chosen by a one-hot select with lowest-index priority and a
//   conflict flag. The ALU takes A from Y and B from the bus when a start is
//   accepted. Logic, shift and add-type ops finish on the accepting edge.
//   Signed MUL (shift-add) and DIV (restoring) step iteratively through a
//   SETUP/ITER/FIX sequence.
//
// Parameters
//   WIDTH    datapath width (even, >= 8)
//   NREGS    general register count (power of 2, 2..32)
//   R0_ZERO  1: R0 reads as zero and ignores loads
//
// Ports
//   clk           rising-edge clock
//   clear         synchronous active-high reset, overrides everything
//   out_en        one-hot bus source: R0..Rn-1, HI, LO, ZHI, ZLO, MDR, INPORT, IMM
//   in_en         load enables: R0..Rn-1, HI, LO, Y, MDR, MAR, OUTPORT
//   mdr_read      MDR load source: 1 = mem_data_in, 0 = bus
//   mem_data_in   memory read data
//   inport_data   input port value
//   imm_data      sign-extended immediate
//   alu_op        ALU operation, sampled on an accepted alu_start
//   alu_start     start request, ignored while alu_busy
//   alu_busy      multi-cycle operation in progress
//   alu_done      one-cycle pulse after Z is written (or after a NOP)
//   div_by_zero   sticky divide-by-zero flag, cleared by the next accepted start
//   bus_data      current bus value
//   bus_conflict  more than one out_en bit set
//   mdr_data      MDR contents
//   mar_addr      MAR contents
//   outport_data  output port register
module param_bus_datapath #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter int R0_ZERO = 0
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [NREGS+6:0]     out_en,
  input  logic [NREGS+5:0]     in_en,
  input  logic                 mdr_read,
  input  logic [WIDTH-1:0]     mem_data_in,
  input  logic [WIDTH-1:0]     inport_data,
  input  logic [WIDTH-1:0]     imm_data,
  input  logic [3:0]           alu_op,
  input  logic                 alu_start,
  output logic                 alu_busy,
  output logic                 alu_done,
  output logic                 div_by_zero,
  output logic [WIDTH-1:0]     bus_data,
  output logic                 bus_conflict,
  output logic [WIDTH-1:0]     mdr_data,
  output logic [WIDTH-1:0]     mar_addr,
  output logic [WIDTH-1:0]     outport_data
);

  localparam int NSRC = NREGS + 7;
  localparam int SHW  = $clog2(WIDTH);
  localparam int CW   = $clog2(WIDTH);

  // Bus source indices above the register file
  localparam int S_HI  = NREGS;
  localparam int S_LO  = NREGS + 1;
  localparam int S_ZHI = NREGS + 2;
  localparam int S_ZLO = NREGS + 3;
  localparam int S_MDR = NREGS + 4;
  localparam int S_IN  = NREGS + 5;
  localparam int S_IMM = NREGS + 6;

  // Load enable indices above the register file
  localparam int L_HI  = NREGS;
  localparam int L_LO  = NREGS + 1;
  localparam int L_Y   = NREGS + 2;
  localparam int L_MDR = NREGS + 3;
  localparam int L_MAR = NREGS + 4;
  localparam int L_OUT = NREGS + 5;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHR = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_NEG = 4'd10;
  localparam logic [3:0] OP_NOT = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;
  localparam logic [3:0] OP_DIV = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ITER,
    S_FIX
  } state_t;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] y_reg;
  logic [WIDTH-1:0] z_hi;
  logic [WIDTH-1:0] z_lo;

  // ---------------------------------------------------------------------------
  // Bus
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] src [NSRC];
  logic             src_found;

  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      src[i] = regs[i];
    end
    if (R0_ZERO != 0) begin
      src[0] = '0;
    end
    src[S_HI]  = hi_reg;
    src[S_LO]  = lo_reg;
    src[S_ZHI] = z_hi;
    src[S_ZLO] = z_lo;
    src[S_MDR] = mdr_data;
    src[S_IN]  = inport_data;
    src[S_IMM] = imm_data;
  end

  // Lowest set index wins so a conflicting select still yields a defined value.
  always_comb begin
    bus_data  = '0;
    src_found = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (out_en[i] && !src_found) begin
        bus_data  = src[i];
        src_found = 1'b1;
      end
    end
  end

  // x & (x-1) is nonzero exactly when two or more bits are set.
  assign bus_conflict = |(out_en & (out_en - NSRC'(1)));

  // ---------------------------------------------------------------------------
  // Register loads
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      hi_reg       <= '0;
      lo_reg       <= '0;
      y_reg        <= '0;
      mdr_data     <= '0;
      mar_addr     <= '0;
      outport_data <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (in_en[i] && !(R0_ZERO != 0 && i == 0)) begin
          regs[i] <= bus_data;
        end
      end
      if (in_en[L_HI])  hi_reg       <= bus_data;
      if (in_en[L_LO])  lo_reg       <= bus_data;
      if (in_en[L_Y])   y_reg        <= bus_data;
      if (in_en[L_MDR]) mdr_data     <= mdr_read ? mem_data_in : bus_data;
      if (in_en[L_MAR]) mar_addr     <= bus_data;
      if (in_en[L_OUT]) outport_data <= bus_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Single-cycle ALU (A = Y, B = bus)
  // ---------------------------------------------------------------------------
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] rot_dbl;
  logic [WIDTH-1:0]   sc_lo;
  logic [WIDTH-1:0]   sc_hi;
  logic               sc_sext;
  logic               sc_valid;

  assign shamt = bus_data[SHW-1:0];

  always_comb begin
    sc_lo    = '0;
    sc_sext  = 1'b0;
    sc_valid = 1'b1;
    rot_dbl  = '0;
    case (alu_op)
      OP_ADD: begin sc_lo = y_reg + bus_data; sc_sext = 1'b1; end
      OP_SUB: begin sc_lo = y_reg - bus_data; sc_sext = 1'b1; end
      OP_AND: sc_lo = y_reg & bus_data;
      OP_OR:  sc_lo = y_reg | bus_data;
      OP_XOR: sc_lo = y_reg ^ bus_data;
      OP_SHR: sc_lo = y_reg >> shamt;
      OP_SRA: sc_lo = $signed(y_reg) >>> shamt;
      OP_SHL: sc_lo = y_reg << shamt;
      // Rotates shift a doubled copy so the wrapped bits fall into place.
      OP_ROR: begin
        rot_dbl = {y_reg, y_reg} >> shamt;
        sc_lo   = rot_dbl[WIDTH-1:0];
      end
      OP_ROL: begin
        rot_dbl = {y_reg, y_reg} << shamt;
        sc_lo   = rot_dbl[2*WIDTH-1:WIDTH];
      end
      OP_NEG: begin sc_lo = '0 - bus_data; sc_sext = 1'b1; end
      OP_NOT: sc_lo = ~bus_data;
      default: sc_valid = 1'b0;
    endcase
  end

  assign sc_hi = sc_sext ? {WIDTH{sc_lo[WIDTH-1]}} : '0;

  // ---------------------------------------------------------------------------
  // Iterative MUL / DIV
  // ---------------------------------------------------------------------------
  state_t             state;
  logic               is_div;
  logic               a_neg;
  logic               b_neg;
  logic               dz;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   acc_hi;   // MUL: partial product high; DIV: remainder
  logic [WIDTH-1:0]   acc_lo;   // MUL: multiplier / product low; DIV: quotient
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  // Remainder stays below the divisor, so the top bit of the trial is a clean
  // borrow indicator.
  assign div_trial = div_shift - {1'b0, mag_b};
  assign prod      = {acc_hi, acc_lo};

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= S_IDLE;
      is_div      <= 1'b0;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      dz          <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      mag_b       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      cnt         <= '0;
      z_hi        <= '0;
      z_lo        <= '0;
      alu_busy    <= 1'b0;
      alu_done    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      alu_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (alu_start) begin
            div_by_zero <= 1'b0;
            op_a        <= y_reg;
            op_b        <= bus_data;
            is_div      <= (alu_op == OP_DIV);
            dz          <= 1'b0;
            if (alu_op == OP_MUL || alu_op == OP_DIV) begin
              alu_busy <= 1'b1;
              state    <= S_SETUP;
            end else begin
              alu_done <= 1'b1;
              if (sc_valid) begin
                z_hi <= sc_hi;
                z_lo <= sc_lo;
              end
            end
          end
        end

        S_SETUP: begin
          a_neg  <= op_a[WIDTH-1];
          b_neg  <= op_b[WIDTH-1];
          acc_hi <= '0;
          acc_lo <= op_a[WIDTH-1] ? ('0 - op_a) : op_a;
          mag_b  <= op_b[WIDTH-1] ? ('0 - op_b) : op_b;
          cnt    <= '0;
          if (is_div && op_b == '0) begin
            dz    <= 1'b1;
            state <= S_FIX;
          end else begin
            state <= S_ITER;
          end
        end

        S_ITER: begin
          if (is_div) begin
            if (!div_trial[WIDTH]) begin
              acc_hi <= div_trial[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= S_FIX;
          end
        end

        S_FIX: begin
          if (dz) begin
            z_lo        <= '1;
            z_hi        <= op_a;
            div_by_zero <= 1'b1;
          end else if (is_div) begin
            z_lo <= (a_neg ^ b_neg) ? ('0 - acc_lo) : acc_lo;
            z_hi <= a_neg ? ('0 - acc_hi) : acc_hi;
          end else begin
            {z_hi, z_lo} <= (a_neg ^ b_neg) ? ('0 - prod) : prod;
          end
          alu_busy <= 1'b0;
          alu_done <= 1'b1;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_bus_datapath.sv
// tb_param_bus_datapath
//   Directed bench for param_bus_datapath (WIDTH=32, NREGS=16, R0_ZERO=1).
//   Inputs change 1 time unit after a rising edge; outputs are compared a
//   little later in the same cycle. Expected values are hand-computed.
module tb_param_bus_datapath;

  localparam int W = 32;
  localparam int N = 16;

  localparam int O_ZHI = N + 2;
  localparam int O_ZLO = N + 3;
  localparam int O_MDR = N + 4;
  localparam int O_IN  = N + 5;
  localparam int O_IMM = N + 6;

  localparam int I_Y   = N + 2;
  localparam int I_MDR = N + 3;
  localparam int I_MAR = N + 4;
  localparam int I_OUT = N + 5;

  logic           clk;
  logic           clear;
  logic [N+6:0]   out_en;
  logic [N+5:0]   in_en;
  logic           mdr_read;
  logic [W-1:0]   mem_data_in;
  logic [W-1:0]   inport_data;
  logic [W-1:0]   imm_data;
  logic [3:0]     alu_op;
  logic           alu_start;
  logic           alu_busy;
  logic           alu_done;
  logic           div_by_zero;
  logic [W-1:0]   bus_data;
  logic           bus_conflict;
  logic [W-1:0]   mdr_data;
  logic [W-1:0]   mar_addr;
  logic [W-1:0]   outport_data;

  int total;
  int bad;

  param_bus_datapath #(
    .WIDTH   (W),
    .NREGS   (N),
    .R0_ZERO (1)
  ) dut (
    .clk          (clk),
    .clear        (clear),
    .out_en       (out_en),
    .in_en        (in_en),
    .mdr_read     (mdr_read),
    .mem_data_in  (mem_data_in),
    .inport_data  (inport_data),
    .imm_data     (imm_data),
    .alu_op       (alu_op),
    .alu_start    (alu_start),
    .alu_busy     (alu_busy),
    .alu_done     (alu_done),
    .div_by_zero  (div_by_zero),
    .bus_data     (bus_data),
    .bus_conflict (bus_conflict),
    .mdr_data     (mdr_data),
    .mar_addr     (mar_addr),
    .outport_data (outport_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_src(input int idx, output logic [W-1:0] val);
    out_en      = '0;
    out_en[idx] = 1'b1;
    #1;
    val    = bus_data;
    out_en = '0;
  endtask

  task automatic load_from_imm(input int dst, input logic [W-1:0] v);
    imm_data     = v;
    out_en       = '0;
    out_en[O_IMM] = 1'b1;
    in_en        = '0;
    in_en[dst]   = 1'b1;
    step();
    out_en = '0;
    in_en  = '0;
  endtask

  // n = edges after the accepting edge until alu_done is seen (0 = same edge)
  task automatic run_alu(input logic [3:0] op, input logic [W-1:0] b, output int n);
    imm_data      = b;
    out_en        = '0;
    out_en[O_IMM] = 1'b1;
    alu_op        = op;
    alu_start     = 1'b1;
    step();
    alu_start = 1'b0;
    out_en    = '0;
    n = 0;
    while (!alu_done && n < 60) begin
      step();
      n++;
    end
  endtask

  initial begin
    logic [W-1:0] v;
    int n;
    logic seen_done;

    total       = 0;
    bad         = 0;
    clear       = 1'b1;
    out_en      = '0;
    in_en       = '0;
    mdr_read    = 1'b0;
    mem_data_in = '0;
    inport_data = '0;
    imm_data    = '0;
    alu_op      = '0;
    alu_start   = 1'b0;
    step();
    step();
    clear = 1'b0;

    // Reset state
    check("rst_bus", bus_data, 0);
    check("rst_busy", alu_busy, 0);
    check("rst_done", alu_done, 0);
    check("rst_dz", div_by_zero, 0);
    check("rst_mdr", mdr_data, 0);
    check("rst_mar", mar_addr, 0);
    check("rst_out", outport_data, 0);
    read_src(O_ZLO, v); check("rst_zlo", v, 0);

    // Register transfers and bus selection
    imm_data = 32'h0000_00A5;
    out_en = '0; out_en[O_IMM] = 1'b1;
    in_en  = '0; in_en[3] = 1'b1;
    #1;
    check("imm_bus", bus_data, 32'hA5);
    check("imm_conflict", bus_conflict, 0);
    step();
    out_en = '0; out_en[3] = 1'b1;
    in_en  = '0; in_en[5] = 1'b1;
    #1;
    check("r3_bus", bus_data, 32'hA5);
    check("r3_conflict", bus_conflict, 0);
    step();
    out_en = '0; in_en = '0;
    load_from_imm(3, 32'h0000_003C);
    read_src(5, v); check("r5_val", v, 32'hA5);
    out_en = '0; out_en[3] = 1'b1; out_en[5] = 1'b1;
    #1;
    check("r3r5_conflict", bus_conflict, 1);
    check("r3r5_bus", bus_data, 32'h3C);
    inport_data = 32'h11; imm_data = 32'h22;
    out_en = '0; out_en[O_IN] = 1'b1; out_en[O_IMM] = 1'b1;
    #1;
    check("in_imm_conflict", bus_conflict, 1);
    check("in_imm_bus", bus_data, 32'h11);
    out_en = '0;
    #1;
    check("idle_bus", bus_data, 0);

    // ADD overflow wraps; ZHI is sign extension
    load_from_imm(I_Y, 32'h7FFF_FFFF);
    run_alu(4'd0, 32'd1, n);
    check("add_lat", n, 0);
    check("add_busy", alu_busy, 0);
    read_src(O_ZLO, v); check("add_zlo", v, 32'h8000_0000);
    read_src(O_ZHI, v); check("add_zhi", v, 32'hFFFF_FFFF);
    step();
    check("add_done_pulse", alu_done, 0);

    // Shifts and rotates of Y by B[4:0]
    load_from_imm(I_Y, 32'h8000_0001);
    run_alu(4'd6, 32'd4, n);
    read_src(O_ZLO, v); check("sra_zlo", v, 32'hF800_0000);
    read_src(O_ZHI, v); check("sra_zhi", v, 0);
    run_alu(4'd8, 32'd4, n);
    read_src(O_ZLO, v); check("ror_zlo", v, 32'h1800_0000);
    run_alu(4'd9, 32'd1, n);
    read_src(O_ZLO, v); check("rol_zlo", v, 32'h0000_0003);
    run_alu(4'd1, 32'd2, n);
    read_src(O_ZLO, v); check("sub_zlo", v, 32'h7FFF_FFFF);
    read_src(O_ZHI, v); check("sub_zhi", v, 0);

    // MUL -7 * 6 with a stray start while busy and a transfer mid-operation
    load_from_imm(I_Y, 32'hFFFF_FFF9);
    imm_data = 32'd6;
    out_en = '0; out_en[O_IMM] = 1'b1;
    alu_op = 4'd12; alu_start = 1'b1;
    step();
    alu_start = 1'b0; out_en = '0;
    check("mul_busy", alu_busy, 1);
    check("mul_done_early", alu_done, 0);
    n = 0;
    while (!alu_done && n < 60) begin
      if (n == 9) begin
        imm_data = 32'd1; out_en = '0; out_en[O_IMM] = 1'b1;
        alu_op = 4'd0; alu_start = 1'b1;
      end
      if (n == 19) begin
        imm_data = 32'h77; out_en = '0; out_en[O_IMM] = 1'b1;
        in_en = '0; in_en[7] = 1'b1;
      end
      step();
      n++;
      alu_start = 1'b0; out_en = '0; in_en = '0;
      if (n == 5) begin
        read_src(O_ZLO, v); check("mul_old_z", v, 32'h7FFF_FFFF);
      end
    end
    check("mul_lat", n, 34);
    check("mul_busy_end", alu_busy, 0);
    read_src(O_ZLO, v); check("mul_zlo", v, 32'hFFFF_FFD6);
    read_src(O_ZHI, v); check("mul_zhi", v, 32'hFFFF_FFFF);
    read_src(7, v); check("busy_xfer", v, 32'h77);
    step();
    check("mul_done_pulse", alu_done, 0);

    // DIV -100 / 7
    load_from_imm(I_Y, 32'hFFFF_FF9C);
    run_alu(4'd13, 32'd7, n);
    check("div_lat", n, 34);
    read_src(O_ZLO, v); check("div_q", v, 32'hFFFF_FFF2);
    read_src(O_ZHI, v); check("div_r", v, 32'hFFFF_FFFE);
    check("div_dz", div_by_zero, 0);

    // Most negative / -1
    load_from_imm(I_Y, 32'h8000_0000);
    run_alu(4'd13, 32'hFFFF_FFFF, n);
    read_src(O_ZLO, v); check("divmin_q", v, 32'h8000_0000);
    read_src(O_ZHI, v); check("divmin_r", v, 0);
    check("divmin_dz", div_by_zero, 0);

    // Divide by zero, then a NOP clears the flag and leaves Z alone
    load_from_imm(I_Y, 32'd5);
    run_alu(4'd13, 32'd0, n);
    check("dz_lat", n, 2);
    check("dz_flag", div_by_zero, 1);
    read_src(O_ZLO, v); check("dz_zlo", v, 32'hFFFF_FFFF);
    read_src(O_ZHI, v); check("dz_zhi", v, 32'd5);
    run_alu(4'd14, 32'd9, n);
    check("nop_lat", n, 0);
    check("nop_clears_dz", div_by_zero, 0);
    read_src(O_ZLO, v); check("nop_zlo", v, 32'hFFFF_FFFF);

    // clear aborts a MUL in progress
    load_from_imm(I_Y, 32'd3);
    imm_data = 32'd5;
    out_en = '0; out_en[O_IMM] = 1'b1;
    alu_op = 4'd12; alu_start = 1'b1;
    step();
    alu_start = 1'b0; out_en = '0;
    for (int i = 0; i < 15; i++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("abort_busy", alu_busy, 0);
    check("abort_done", alu_done, 0);
    read_src(O_ZLO, v); check("abort_zlo", v, 0);
    read_src(O_ZHI, v); check("abort_zhi", v, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (alu_done) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 0);
    load_from_imm(I_Y, 32'd3);
    run_alu(4'd12, 32'd5, n);
    check("mul2_lat", n, 34);
    read_src(O_ZLO, v); check("mul2_zlo", v, 32'd15);
    read_src(O_ZHI, v); check("mul2_zhi", v, 0);

    // R0 hardwired zero, MDR memory path, MAR and OUTPORT
    load_from_imm(0, 32'h1234);
    read_src(0, v); check("r0_zero", v, 0);
    mdr_read = 1'b1; mem_data_in = 32'hDEAD_BEEF;
    in_en = '0; in_en[I_MDR] = 1'b1;
    step();
    in_en = '0; mdr_read = 1'b0;
    check("mdr_mem", mdr_data, 32'hDEAD_BEEF);
    out_en = '0; out_en[O_MDR] = 1'b1;
    in_en = '0; in_en[I_OUT] = 1'b1;
    step();
    out_en = '0; in_en = '0;
    check("outport", outport_data, 32'hDEAD_BEEF);
    load_from_imm(I_MAR, 32'h0000_0100);
    check("mar", mar_addr, 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_bus_datapath.md
Name: param_bus_datapath

Overview:
- Parametrised successor to the single-bus processor datapath.
- Contains a NREGS x WIDTH general register file, HI/LO, Y, 2*WIDTH-bit Z, MDR, MAR and in/out ports around one shared bus.
- Bus source selection is one-hot with conflict detection, replacing the encoder.
- The ALU has a start/busy/done handshake: logic ops complete in 1 cycle; signed MUL and DIV run iteratively over multiple cycles.

Parameters:
- WIDTH, 32, datapath width in bits; even, >= 8.
- NREGS, 16, number of general registers; power of 2, 2..32.
- R0_ZERO, 0, 1 makes R0 read as zero and ignore writes.

Ports:
- clk  in  1  rising-edge clock.
- clear  in  1  synchronous active-high reset.
- out_en  in  NREGS+7  one-hot bus source select. Bits [NREGS-1:0] select R0..Rn. Then, in order: HI, LO, ZHI, ZLO, MDR, INPORT, IMM.
- in_en  in  NREGS+6  load enables. Bits [NREGS-1:0] select R0..Rn. Then, in order: HI, LO, Y, MDR, MAR, OUTPORT.
- mdr_read  in  1  with MDR load: 1 loads mem_data_in, 0 loads bus.
- mem_data_in  in  WIDTH  memory read data.
- inport_data  in  WIDTH  input port value.
- imm_data  in  WIDTH  sign-extended immediate.
- alu_op  in  4  operation code, sampled on alu_start.
- alu_start  in  1  start pulse.
- alu_busy  out  1  operation in progress.
- alu_done  out  1  one-cycle pulse when Z is updated.
- div_by_zero  out  1  sticky; cleared by the next accepted alu_start.
- bus_data  out  WIDTH  current bus value.
- bus_conflict  out  1  more than one out_en bit set (combinational).
- mdr_data  out  WIDTH  MDR contents, to memory.
- mar_addr  out  WIDTH  MAR contents.
- outport_data  out  WIDTH  output port register.

Behaviour:
- Reset: on clk edge with clear=1, every register, Y, Z, MDR, MAR, OUTPORT, alu_busy, alu_done and div_by_zero go to 0. clear has priority over all enables and aborts any ALU operation in progress.
- Bus (combinational):
  - No out_en bit set: bus = 0.
  - Multiple bits set: bus_conflict=1 and bus = source with the lowest bit index.
- Loads: on clk edge, every destination with its in_en bit set captures bus (MDR: mem_data_in if mdr_read). Multiple simultaneous loads are legal.
- R0_ZERO=1: R0 always sources 0 and ignores in_en[0].
- ALU operands: A = Y; B = bus, both latched on the cycle alu_start is accepted. alu_start is accepted only when alu_busy=0; starts while busy are ignored and have no effect.
- Single-cycle ops; Z loads at the next edge, alu_done=1 that cycle, alu_busy never asserts:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR.
  - 5 SHR logical, 6 SRA, 7 SHL, 8 ROR, 9 ROL; shift amount = B[log2(WIDTH)-1:0].
  - 10 NEG (-B), 11 NOT (~B).
  - Result goes to ZLO; ZHI gets the sign-extension of the ADD/SUB/NEG result and 0 otherwise.
  - Arithmetic wraps modulo 2^WIDTH.
- 12 MUL (signed, 2*WIDTH-bit product in {ZHI,ZLO}):
  - FSM IDLE -> SETUP (take magnitudes) -> ITER (WIDTH shift-add steps, counter 0..WIDTH-1) -> FIX (apply sign, write Z) -> IDLE.
  - alu_busy=1 from the edge accepting start until the FIX edge; alu_done=1 for the cycle after FIX.
  - Total latency start-edge to done = WIDTH+2 cycles.
- 13 DIV (signed, restoring; same FSM and latency):
  - ZLO = quotient truncated toward zero; ZHI = remainder with the sign of the dividend.
  - B=0: skip ITER; FIX writes ZLO = all-ones, ZHI = A; div_by_zero=1; latency 2 cycles.
  - Most negative / -1: quotient = most negative, remainder 0; no flag.
- Opcodes 14-15: NOP; alu_done pulses after 1 cycle and Z is unchanged.
- Z changes only via ALU completion. Bus reads of ZHI/ZLO during busy return the previous Z.
- Register transfers on the bus remain legal while busy.

Test Plan:
- Reset, then load bus from IMM=0x0000_00A5 with in_en R3, then out_en R3 + in_en R5 -> R5=0xA5, bus_conflict=0. Next: out_en R3|R5 -> bus_conflict=1, bus=R3 value.
- Y=0x7FFF_FFFF, start ADD with bus=1 -> after 1 cycle ZLO=0x8000_0000, ZHI=0xFFFF_FFFF, alu_done single pulse, alu_busy never 1.
- Y=-7 (0xFFFF_FFF9), MUL with bus=6 -> alu_done at cycle 34, {ZHI,ZLO}=0xFFFF_FFFF_FFFF_FFD6. A second alu_start at cycle 10 is ignored.
- Y=-100, DIV with bus=7 -> ZLO=-14 (0xFFFF_FFF2), ZHI=-2 (0xFFFF_FFFE). Y=5, DIV with bus=0 -> done after 2 cycles, ZLO=0xFFFF_FFFF, ZHI=5, div_by_zero=1; the next start clears the flag.
- clear asserted at cycle 15 of a MUL -> next cycle alu_busy=0, Z=0, no alu_done pulse. A new MUL then completes normally.
- R0_ZERO=1, in_en[0] with bus=0x1234 -> out_en R0 drives bus=0. mdr_read=1 with mem_data_in=0xDEAD_BEEF -> mdr_data=0xDEAD_BEEF. MDR->bus with in_en OUTPORT -> outport_data=0xDEAD_BEEF.
